// File: rtl/mapreduce_pkg.sv
// Shared types and defaults for the map/reduce datapath blocks.
package mapreduce_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } disp_state_e;

   localparam int unsigned DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/dispatch_delay_line.sv
// Fixed-latency valid/data/last shift register that lines a popped data point
// up with the registered mapper grant; synchronous clear empties every stage.
module dispatch_delay_line #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned LATENCY = 2
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             last_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             last_o
);

   logic [LATENCY-1:0]            valid_q, last_q;
   logic [LATENCY-1:0][WIDTH-1:0] data_q;
   logic [LATENCY:0]              valid_chain, last_chain;
   logic [LATENCY:0][WIDTH-1:0]   data_chain;

   // Input prepended at index 0 so a single slice shifts for any LATENCY >= 1.
   assign valid_chain = {valid_q, valid_i};
   assign last_chain  = {last_q, last_i};
   assign data_chain  = {data_q, data_i};

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         valid_q <= '0;
         last_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_chain[LATENCY-1:0];
         last_q  <= last_chain[LATENCY-1:0];
         data_q  <= data_chain[LATENCY-1:0];
      end
   end

   assign valid_o = valid_q[LATENCY-1];
   assign last_o  = last_q[LATENCY-1];
   assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/fifo_dc.sv
// Team FIFO: synchronous single-clock buffer with show-ahead read port and
// occupancy-derived full/empty flags.
module fifo_dc #(
   parameter int unsigned WIDTH     = 33,
   parameter int unsigned LOG_DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned DEPTH = 1 << LOG_DEPTH;
   localparam logic [LOG_DEPTH:0]   FULL_CNT = {1'b1, {LOG_DEPTH{1'b0}}};
   localparam logic [LOG_DEPTH:0]   CNT_ONE  = (LOG_DEPTH + 1)'(1);
   localparam logic [LOG_DEPTH-1:0] PTR_ONE  = LOG_DEPTH'(1);

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [LOG_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [LOG_DEPTH:0]   count_q, count_d;
   logic                 push, pop;

   assign full_o    = (count_q == FULL_CNT);
   assign empty_o   = (count_q == '0);
   assign push      = wr_en_i && !full_o;
   assign pop       = rd_en_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointers wrap naturally at LOG_DEPTH bits; storage itself is never cleared.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q        <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/data_dispatcher.sv
// Buffers data points and pops one per available mapper grant, delaying it to meet
// the grant. Optional saturating dispatch counter: define DATA_DISPATCHER_COUNT_EN.
module data_dispatcher
   import mapreduce_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
   parameter int unsigned C_LOG_BUF_DEPTH = 2,
   parameter int unsigned GRANT_LATENCY   = 2
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   input  logic                  fifo_empty,
   output logic                  fifo_re,
   output logic [DATA_WIDTH-1:0] data_point,
   output logic                  data_valid,
   output logic                  busy,
   output logic                  done
`ifdef DATA_DISPATCHER_COUNT_EN
   ,
   output logic [31:0]           dispatched_count
`endif
);

   disp_state_e           state_q, state_d;
   logic                  buf_full, buf_empty, push, start_acc, clr, out_last;
   logic [DATA_WIDTH:0]   buf_rd;
   logic [DATA_WIDTH-1:0] line_data;
   logic                  line_last;

   assign start_acc = start && (state_q == IDLE || state_q == DONE);
   assign clr       = rst || start_acc;
   assign push      = in_valid && in_ready;

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      fifo_re  = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            busy     = 1'b1;
            in_ready = !buf_full;
            fifo_re  = !buf_empty && !fifo_empty;
            if (in_valid && !buf_full && in_last) state_d = DRAIN;
         end
         DRAIN: begin
            busy    = 1'b1;
            fifo_re = !buf_empty && !fifo_empty;
            if (data_valid && out_last) state_d = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   fifo_dc #(
      .WIDTH     (DATA_WIDTH + 1),
      .LOG_DEPTH (C_LOG_BUF_DEPTH)
   ) u_buf (
      .clk_i     (clock),
      .rst_i     (rst),
      .clr_i     (start_acc),
      .wr_en_i   (push),
      .wr_data_i ({in_last, in_data}),
      .rd_en_i   (fifo_re),
      .rd_data_o (buf_rd),
      .full_o    (buf_full),
      .empty_o   (buf_empty)
   );

   // Bubbles carry zero so data_point never shows stale buffer contents.
   assign line_data = fifo_re ? buf_rd[DATA_WIDTH-1:0] : '0;
   assign line_last = fifo_re && buf_rd[DATA_WIDTH];

   dispatch_delay_line #(
      .WIDTH   (DATA_WIDTH),
      .LATENCY (GRANT_LATENCY)
   ) u_delay (
      .clk_i   (clock),
      .clr_i   (clr),
      .valid_i (fifo_re),
      .data_i  (line_data),
      .last_i  (line_last),
      .valid_o (data_valid),
      .data_o  (data_point),
      .last_o  (out_last)
   );

`ifdef DATA_DISPATCHER_COUNT_EN
   logic [31:0] count_q;

   always_ff @(posedge clock) begin
      if (clr)                               count_q <= '0;
      else if (data_valid && count_q != '1)  count_q <= count_q + 32'd1;
   end

   assign dispatched_count = count_q;
`endif

endmodule

// File: tb/tb_data_dispatcher.sv
// Randomised/directed bench for data_dispatcher against a queue-based reference model.
module tb_data_dispatcher;

   localparam int DW    = 32;
   localparam int LOGD  = 2;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;

   logic          clock = 1'b0;
   logic          rst, start, in_valid, in_last, fifo_empty;
   logic [DW-1:0] in_data;
   logic          in_ready, fifo_re, data_valid, busy, done;
   logic [DW-1:0] data_point;
`ifdef DATA_DISPATCHER_COUNT_EN
   logic [31:0]   dispatched_count;
`endif

   always #5 clock = ~clock;

   data_dispatcher #(
      .DATA_WIDTH      (DW),
      .C_LOG_BUF_DEPTH (LOGD),
      .GRANT_LATENCY   (LAT)
   ) dut (
      .clock      (clock),
      .rst        (rst),
      .start      (start),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .fifo_empty (fifo_empty),
      .fifo_re    (fifo_re),
      .data_point (data_point),
      .data_valid (data_valid),
      .busy       (busy),
      .done       (done)
`ifdef DATA_DISPATCHER_COUNT_EN
      ,
      .dispatched_count (dispatched_count)
`endif
   );

   typedef struct {
      int            due;
      logic [DW-1:0] d;
      bit            last;
   } pent_t;

   // Model: mstate 0 idle, 1 run, 2 drain, 3 done.
   logic [DW:0] bufq[$];
   pent_t       pipe[$];
   int          mstate = 0;
   int          cyc = 0;
   int unsigned mcount = 0;
   int          obs_valid = 0;
   int          checks = 0;
   int          failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input bit do_check, output bit accepted);
      bit            exp_rdy, exp_re, outv, outl, sacc, push;
      logic [DW-1:0] outd;
      logic [DW:0]   e;
      @(negedge clock);
      exp_rdy = (mstate == 1) && (bufq.size() < DEPTH);
      exp_re  = (mstate == 1 || mstate == 2) && (bufq.size() > 0) && !fifo_empty;
      outv    = (pipe.size() > 0) && (pipe[0].due == cyc);
      outd    = outv ? pipe[0].d : '0;
      outl    = outv && pipe[0].last;
      if (do_check) begin
         chk("in_ready",   32'(in_ready),   32'(exp_rdy));
         chk("fifo_re",    32'(fifo_re),    32'(exp_re));
         chk("data_valid", 32'(data_valid), 32'(outv));
         chk("data_point", data_point,      outd);
         chk("busy",       32'(busy),       32'(mstate == 1 || mstate == 2));
         chk("done",       32'(done),       32'(mstate == 3));
`ifdef DATA_DISPATCHER_COUNT_EN
         chk("count",      dispatched_count, mcount);
`endif
      end
      if (data_valid === 1'b1) obs_valid++;
      push = in_valid && exp_rdy;
      sacc = start && (mstate == 0 || mstate == 3);
      accepted = push && !rst;
      if (rst) begin
         bufq.delete(); pipe.delete(); mstate = 0; mcount = 0;
      end else if (sacc) begin
         bufq.delete(); pipe.delete(); mstate = 1; mcount = 0;
      end else begin
         if (outv) begin
            void'(pipe.pop_front());
            if (mcount != 32'hFFFF_FFFF) mcount++;
            if (mstate == 2 && outl) mstate = 3;
         end
         if (exp_re) begin
            e = bufq.pop_front();
            pipe.push_back('{due: cyc + LAT, d: e[DW-1:0], last: e[DW]});
         end
         if (push) begin
            bufq.push_back({in_last, in_data});
            if (in_last) mstate = 2;
         end
      end
      cyc++;
      @(posedge clock);
      #1;
   endtask

   // em: 0 grants always available, 1 random, 2 toggle every 3 cycles, 3 none for 8 cycles
   task automatic stream(input int n, input int em, input bit rnd, input logic [31:0] base);
      int idx, k;
      bit acc;
      obs_valid = 0;
      start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      cycle(1'b1, acc);
      start = 1'b0;
      idx = 0; k = 0;
      while ((idx < n || mstate != 3) && k < 400) begin
         in_valid = (idx < n) && (!rnd || $urandom_range(3) != 0);
         in_data  = rnd ? $urandom : base + 32'(idx);
         in_last  = (idx == n - 1);
         case (em)
            0:       fifo_empty = 1'b0;
            1:       fifo_empty = ($urandom_range(2) == 0);
            2:       fifo_empty = (((k / 3) % 2) == 1);
            default: fifo_empty = (k < 8);
         endcase
         cycle(1'b1, acc);
         if (acc) idx++;
         k++;
      end
      in_valid = 1'b0; in_last = 1'b0; fifo_empty = 1'b1;
      chk("stream_accepted", 32'(idx),       32'(n));
      chk("stream_done",     32'(done),      32'd1);
      chk("stream_busy",     32'(busy),      32'd0);
      chk("stream_outputs",  32'(obs_valid), 32'(n));
`ifdef DATA_DISPATCHER_COUNT_EN
      chk("stream_count",    dispatched_count, 32'(n));
`endif
   endtask

   initial begin
      bit acc;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      fifo_empty = 1'b1; in_data = '0;
      @(posedge clock); #1;
      cycle(1'b0, acc);
      cycle(1'b0, acc);
      rst = 1'b0;
      cycle(1'b1, acc);
      cycle(1'b1, acc);

      // Reset mid-stream discards buffered points; no activity until a new start.
      start = 1'b1; cycle(1'b1, acc); start = 1'b0;
      in_valid = 1'b1; in_data = 32'h11; cycle(1'b1, acc);
      in_data = 32'h22; cycle(1'b1, acc);
      in_valid = 1'b0; rst = 1'b1; cycle(1'b1, acc); rst = 1'b0;
      fifo_empty = 1'b0; in_valid = 1'b1; in_data = 32'h33;
      for (int i = 0; i < 4; i++) cycle(1'b1, acc);
      chk("rst_fifo_re",    32'(fifo_re),    32'd0);
      chk("rst_in_ready",   32'(in_ready),   32'd0);
      chk("rst_data_valid", 32'(data_valid), 32'd0);
      chk("rst_data_point", data_point,      32'd0);
      in_valid = 1'b0; fifo_empty = 1'b1;

      stream(8, 0, 1'b0, 32'hA0);   // streaming
      stream(5, 3, 1'b0, 32'hB0);   // buffer fills, grants released later
      stream(3, 0, 1'b0, 32'hD0);   // end of stream
      stream(6, 0, 1'b0, 32'hC0);   // dispatch count
      stream(20, 2, 1'b0, 32'h0);   // wrap-around, order 0..19
      for (int s = 0; s < 4; s++) stream(int'($urandom_range(12, 1)), 1, 1'b1, 32'h0);

      // start in RUN is ignored
      start = 1'b1; cycle(1'b1, acc); start = 1'b0;
      in_valid = 1'b1; in_data = 32'h55; fifo_empty = 1'b1; cycle(1'b1, acc);
      start = 1'b1; cycle(1'b1, acc); start = 1'b0;
      chk("ignored_start_busy", 32'(busy), 32'd1);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) cycle(1'b1, acc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
